alu_issue_unit: RTL and testbench

ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

---
 rtl/alu_issue_if.sv | 28 ++
 rtl/alu_issue_unit.sv | 134 +++++++++++++
 tb/tb_alu_issue_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Request/response channels between a requester and alu_issue_unit.
// The unit connects to the slave modport.
interface alu_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_fn;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_tag;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_err;
    logic [3:0]  rsp_tag;

    modport master (
        output req_valid, req_fn, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_fn, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Single-outstanding issue stage for an external combinational ALU: registers the operands,
// waits SETTLE_CYCLES for the ALU to settle, captures the result and returns it with its tag.
module alu_issue_unit #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fn,
    input  logic [31:0] alu_otp,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_fn_q, alu_fn_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;
    logic [3:0]  tag_q, tag_d;
    logic [15:0] op_count_q, op_count_d;
    logic        fn_legal;

    always_comb begin
        fn_legal = 1'b0;
        case (bus.req_fn)
            6'b000000, 6'b000001, 6'b000010, 6'b000100,
            6'b000101, 6'b000110, 6'b001000, 6'b001001: fn_legal = 1'b1;
            default: fn_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fn_d   = alu_fn_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        err_d      = err_q;
        tag_d      = tag_q;
        op_count_d = op_count_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    tag_d = bus.req_tag;
                    if (fn_legal) begin
                        alu_a_d  = bus.req_a;
                        alu_b_d  = bus.req_b;
                        alu_fn_d = bus.req_fn;
                        cnt_d    = 4'(SETTLE_CYCLES - 1);
                        state_d  = StDrive;
                    end else begin
                        // Illegal codes bypass the ALU and answer immediately.
                        result_d = 32'h0;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StDrive: begin
                if (cnt_q == 4'd0) begin
                    result_d = alu_otp;
                    ovf_d    = alu_overflow;
                    zero_d   = alu_zero;
                    err_d    = 1'b0;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            alu_a_q    <= 32'h0;
            alu_b_q    <= 32'h0;
            alu_fn_q   <= 6'h0;
            cnt_q      <= 4'd0;
            result_q   <= 32'h0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            tag_q      <= 4'd0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fn_q   <= alu_fn_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
            tag_q      <= tag_d;
            op_count_q <= op_count_d;
        end
    end

    // Handshake outputs are gated by rst so nothing is offered while reset is held.
    assign bus.req_ready    = (state_q == StIdle) && !rst;
    assign bus.rsp_valid    = (state_q == StResp) && !rst;
    assign bus.rsp_result   = result_q;
    assign bus.rsp_overflow = ovf_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_err      = err_q;
    assign bus.rsp_tag      = tag_q;
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_fn           = alu_fn_q;
    assign op_count         = op_count_q;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: a driver queues expected responses, a monitor checks them;
// a second instance with SETTLE_CYCLES=4 covers long settle and reset abort.
module tb_alu_issue_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_if bus ();
    alu_issue_if bus2 ();

    logic [31:0] alu_a, alu_b, alu_otp, alu_a2, alu_b2, alu_otp2;
    logic [5:0]  alu_fn, alu_fn2;
    logic        alu_ov, alu_zero, alu_ov2, alu_zero2;
    logic [15:0] op_count, op_count2;

    function automatic logic [33:0] alu_model(input logic [5:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (fn)
            6'b000000: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            6'b000001: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            6'b000010: r = a * b;
            6'b000100: r = a & b;
            6'b000101: r = a | b;
            6'b000110: r = a ^ b;
            6'b001000: r = a << b[4:0];
            6'b001001: r = a >> b[4:0];
            default:   r = 32'hBAD0_BAD0;
        endcase
        return {ov, (r == 32'h0), r};
    endfunction

    assign {alu_ov, alu_zero, alu_otp}    = alu_model(alu_fn, alu_a, alu_b);
    assign {alu_ov2, alu_zero2, alu_otp2} = alu_model(alu_fn2, alu_a2, alu_b2);

    alu_issue_unit #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
        .alu_otp(alu_otp), .alu_overflow(alu_ov), .alu_zero(alu_zero), .op_count(op_count)
    );

    alu_issue_unit #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst2), .bus(bus2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_fn(alu_fn2),
        .alu_otp(alu_otp2), .alu_overflow(alu_ov2), .alu_zero(alu_zero2), .op_count(op_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        zero;
        logic        err;
        logic [3:0]  tag;
        int          lat;
        int          acc;
        int          hold;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    bit          active = 1'b0;
    bit          cnt_check = 1'b0;
    int          hold = 0;
    logic [15:0] exp_count = 16'd0;
    logic [31:0] last_a = 32'h0, last_b = 32'h0;
    logic [5:0]  last_fn = 6'h0;

    // Monitor: pops an expectation when a response appears and drives rsp_ready.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt_check) begin
                check("op_count", 32'(op_count), 32'(exp_count));
                check("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
                check("req_ready_after", 32'(bus.req_ready), 32'd1);
                bus.rsp_ready = 1'b0;
                cnt_check = 1'b0;
            end else if (bus.rsp_valid) begin
                if (!active) begin
                    if (expq.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                        continue;
                    end
                    cur    = expq.pop_front();
                    active = 1'b1;
                    hold   = cur.hold;
                    check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
                check("rsp_result", bus.rsp_result, cur.res);
                check("rsp_overflow", 32'(bus.rsp_overflow), 32'(cur.ov));
                check("rsp_zero", 32'(bus.rsp_zero), 32'(cur.zero));
                check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                check("rsp_tag", 32'(bus.rsp_tag), 32'(cur.tag));
                check("req_ready_busy", 32'(bus.req_ready), 32'd0);
                if (hold == 0) begin
                    bus.rsp_ready = 1'b1;
                    active        = 1'b0;
                    exp_count     = exp_count + 16'd1;
                    cnt_check     = 1'b1;
                end else begin
                    hold--;
                end
            end
        end
    end

    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] res, input logic ov,
                         input logic zero, input logic err, input int hold_cycles);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("req_ready_timeout", 32'd0, 32'd1);
                return;
            end
        end
        bus.req_valid = 1'b1;
        bus.req_fn    = fn;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        e = '{res: res, ov: ov, zero: zero, err: err, tag: tag, lat: err ? 1 : 2,
              acc: cyc + 1, hold: hold_cycles};
        expq.push_back(e);
        @(negedge clk);
        // Junk on the idle request lines must be ignored.
        bus.req_valid = 1'b0;
        bus.req_fn    = 6'b000001;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'h1234_5678;
        bus.req_tag   = 4'hE;
        if (!err) begin
            last_a  = a;
            last_b  = b;
            last_fn = fn;
        end
        check("alu_a_load", alu_a, last_a);
        check("alu_b_load", alu_b, last_b);
        check("alu_fn_load", 32'(alu_fn), 32'(last_fn));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((expq.size() != 0 || active || cnt_check) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        bus.req_valid  = 1'b0;
        bus.req_fn     = 6'h0;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.req_tag    = 4'h0;
        bus2.req_valid = 1'b0;
        bus2.req_fn    = 6'h0;
        bus2.req_a     = 32'h0;
        bus2.req_b     = 32'h0;
        bus2.req_tag   = 4'h0;
        bus2.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        check("reset_alu_a", alu_a, 32'h0);
        check("reset_alu_b", alu_b, 32'h0);
        check("reset_alu_fn", 32'(alu_fn), 32'h0);
        check("reset_result", bus.rsp_result, 32'h0);
        check("reset_err", 32'(bus.rsp_err), 32'h0);
        check("reset_tag", 32'(bus.rsp_tag), 32'h0);
        check("reset_op_count", 32'(op_count), 32'h0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);

        //      fn         a             b             tag    result        ov    z     err   hold
        issue(6'b000000, 32'h1,        32'h1,        4'd3,  32'h2,        1'b0, 1'b0, 1'b0, 0);
        issue(6'b000001, 32'h13,       32'h13,       4'd1,  32'h0,        1'b0, 1'b1, 1'b0, 0);
        issue(6'b001000, 32'h1,        32'h3,        4'd2,  32'h8,        1'b0, 1'b0, 1'b0, 0);
        issue(6'b001001, 32'h10,       32'h3,        4'd4,  32'h2,        1'b0, 1'b0, 1'b0, 0);
        issue(6'b000011, 32'h55,       32'h66,       4'd7,  32'h0,        1'b0, 1'b0, 1'b1, 0);
        issue(6'b000010, 32'h13,       32'h2,        4'd5,  32'h26,       1'b0, 1'b0, 1'b0, 5);
        issue(6'b000100, 32'hF0F0,     32'hFF00,     4'd6,  32'hF000,     1'b0, 1'b0, 1'b0, 0);
        issue(6'b000101, 32'hF0F0,     32'h0F0F,     4'd8,  32'hFFFF,     1'b0, 1'b0, 1'b0, 1);
        issue(6'b000110, 32'hFF,       32'hFF,       4'd9,  32'h0,        1'b0, 1'b1, 1'b0, 0);
        issue(6'b000000, 32'h7FFFFFFF, 32'h1,        4'd10, 32'h80000000, 1'b1, 1'b0, 1'b0, 0);
        issue(6'b111111, 32'h1,        32'h2,        4'd15, 32'h0,        1'b0, 1'b0, 1'b1, 2);
        wait_idle();
        check("op_count_total", 32'(op_count), 32'd11);

        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        exp_count = 16'hFFFF;
        issue(6'b000000, 32'h2, 32'h3, 4'd0, 32'h5, 1'b0, 1'b0, 1'b0, 0);
        wait_idle();
        check("op_count_wrap", 32'(op_count), 32'h0);

        // Long settle: operands stable for 4 cycles, response on the 5th.
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_fn    = 6'b000000;
        bus2.req_a     = 32'h5;
        bus2.req_b     = 32'h6;
        bus2.req_tag   = 4'd2;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (bus2.rsp_valid) begin
                seen = 1'b1;
            end else begin
                check("s4_alu_a", alu_a2, 32'h5);
                check("s4_alu_b", alu_b2, 32'h6);
                check("s4_alu_fn", 32'(alu_fn2), 32'h0);
                @(negedge clk);
                lat++;
            end
        end
        check("s4_latency", 32'(lat), 32'd5);
        check("s4_result", bus2.rsp_result, 32'd11);
        check("s4_tag", 32'(bus2.rsp_tag), 32'd2);
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        check("s4_op_count", 32'(op_count2), 32'd1);

        // Reset in the second DRIVE cycle aborts the operation.
        bus2.req_valid = 1'b1;
        bus2.req_fn    = 6'b000001;
        bus2.req_a     = 32'h9;
        bus2.req_b     = 32'h4;
        bus2.req_tag   = 4'd6;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        check("abort_req_ready", 32'(bus2.req_ready), 32'd0);
        check("abort_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        rst2 = 1'b0;
        @(negedge clk);
        check("abort_alu_a", alu_a2, 32'h0);
        check("abort_alu_b", alu_b2, 32'h0);
        check("abort_alu_fn", 32'(alu_fn2), 32'h0);
        check("abort_result", bus2.rsp_result, 32'h0);
        check("abort_tag", 32'(bus2.rsp_tag), 32'h0);
        check("abort_op_count", 32'(op_count2), 32'h0);
        bus2.rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus2.rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        check("abort_op_count_hold", 32'(op_count2), 32'h0);
        check("abort_req_ready_idle", 32'(bus2.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
